// File: rtl/ula_pkg.sv
// Shared constants and FSM state type for the sequential logic-unit controller.
package ula_pkg;

    localparam int DATA_W = 6;
    localparam int SEL_W  = 4;

    // Opcodes at or above this value select a logic operation; lower codes are illegal.
    localparam logic [SEL_W-1:0] LOGIC_BASE = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ula_seq.sv
// Command sequencer around an external combinational logic unit: IDLE -> EXEC -> RESP.
// Optional zero-status output is enabled by defining ULA_SEQ_STATUS_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// cmd_ready is high only in IDLE, res_valid only in RESP, and the result is held
// stable until res_ready is seen.
module ula_seq
    import ula_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_load,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] saida_logica,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
`ifdef ULA_SEQ_STATUS_EN
    output logic              zero,
`endif
    output logic [7:0]        op_count,
    output state_t            state_dbg
);

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic              load_r;
    logic [DATA_W-1:0] acc_nxt;
    logic              err_nxt;

    // Outcome of the command in EXEC; B and sel are already the registered command.
    always_comb begin
        acc_nxt = acc;
        err_nxt = 1'b0;
        if (load_r) begin
            acc_nxt = B;
        end else if (sel >= LOGIC_BASE) begin
            acc_nxt = saida_logica;
        end else begin
            err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            A         <= '0;
            B         <= '0;
            sel       <= '0;
            load_r    <= 1'b0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            op_count  <= '0;
`ifdef ULA_SEQ_STATUS_EN
            zero      <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        A      <= acc;
                        B      <= cmd_b;
                        sel    <= cmd_sel;
                        load_r <= cmd_load;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc       <= acc_nxt;
                    res_err   <= err_nxt;
                    res_valid <= 1'b1;
`ifdef ULA_SEQ_STATUS_EN
                    zero      <= (acc_nxt == '0);
`endif
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (!res_err) op_count <= op_count + 8'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The accumulator flop is the result register; it only changes at the end of EXEC.
    assign res_data  = acc;
    assign cmd_ready = (state == ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq with an XOR logic-unit stub and a result/counter model.
// Define ULA_SEQ_STATUS_EN to also exercise the zero output.
module tb_ula_seq;
    import ula_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_sel;
    logic [5:0] cmd_b;
    logic       cmd_load;
    logic [5:0] A;
    logic [5:0] B;
    logic [3:0] sel;
    logic [5:0] saida_logica;
    logic       res_valid;
    logic       res_ready;
    logic [5:0] res_data;
    logic       res_err;
    logic [7:0] op_count;
    state_t     state_dbg;
`ifdef ULA_SEQ_STATUS_EN
    logic       zero;
`endif

    ula_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_b(cmd_b), .cmd_load(cmd_load),
        .A(A), .B(B), .sel(sel), .saida_logica(saida_logica),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err),
`ifdef ULA_SEQ_STATUS_EN
        .zero(zero),
`endif
        .op_count(op_count), .state_dbg(state_dbg)
    );

    // Logic-unit stub
    assign saida_logica = (sel >= 4'd8) ? (A ^ B) : 6'h3F;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [6:0] exp_q[$];   // {err, data}
    logic [5:0] acc_m;
    logic [7:0] cnt_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model whenever the outputs are meaningful.
    always @(negedge clk) begin
        if (rst_n) begin
            check("op_count", {24'd0, op_count}, {24'd0, cnt_m});
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_res_valid", 32'd1, 32'd0);
                end else begin
                    check("res_data", {26'd0, res_data}, {26'd0, exp_q[0][5:0]});
                    check("res_err", {31'd0, res_err}, {31'd0, exp_q[0][6]});
`ifdef ULA_SEQ_STATUS_EN
                    check("zero", {31'd0, zero}, {31'd0, (exp_q[0][5:0] == 6'd0)});
`endif
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_cmd(input logic ld, input logic [3:0] s, input logic [5:0] b,
                           input int stall, input bit abort,
                           output logic [5:0] dout, output logic derr);
        logic [5:0] a_before;
        logic [5:0] d;
        logic       e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = ld; cmd_sel = s; cmd_b = b;
        a_before = acc_m;
        d = acc_m; e = 1'b0;
        if (ld)              d = b;
        else if (s >= 4'd8)  d = acc_m ^ b;
        else                 e = 1'b1;
        acc_m = d;
        exp_q.push_back({e, d});
        @(posedge clk);
        #1;
        // Keep presenting a different command; it must be ignored outside IDLE.
        cmd_sel = ~s; cmd_b = ~b; cmd_load = ~ld;
        @(negedge clk);
        check("exec_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("exec_res_valid", {31'd0, res_valid}, 32'd0);
        check("exec_A", {26'd0, A}, {26'd0, a_before});
        check("exec_B", {26'd0, B}, {26'd0, b});
        check("exec_sel", {28'd0, sel}, {28'd0, s});
        @(negedge clk);
        check("resp_res_valid", {31'd0, res_valid}, 32'd1);
        dout = res_data; derr = res_err;
        if (abort) begin
            rst_n = 1'b0;
            cmd_valid = 1'b0;
            #1;
            exp_q.delete();
            acc_m = 6'd0;
            cnt_m = 8'd0;
            return;
        end
        for (int i = 0; i < stall; i++) begin
            check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("stall_res_valid", {31'd0, res_valid}, 32'd1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        void'(exp_q.pop_front());
        if (!e) cnt_m = cnt_m + 8'd1;
        @(negedge clk);
        check("idle_res_valid", {31'd0, res_valid}, 32'd0);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("idle_A_hold", {26'd0, A}, {26'd0, a_before});
    endtask

    task automatic check_reset_values();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {26'd0, res_data}, 32'd0);
        check("rst_res_err", {31'd0, res_err}, 32'd0);
        check("rst_op_count", {24'd0, op_count}, 32'd0);
        check("rst_A", {26'd0, A}, 32'd0);
        check("rst_B", {26'd0, B}, 32'd0);
        check("rst_sel", {28'd0, sel}, 32'd0);
`ifdef ULA_SEQ_STATUS_EN
        check("rst_zero", {31'd0, zero}, 32'd1);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [5:0] d;
        logic       e;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_b = '0; cmd_load = 1'b0;
        res_ready = 1'b0;
        acc_m = '0; cnt_m = '0;
        #23;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Load, logic op, illegal op with hand-computed results
        run_cmd(1'b1, 4'h0, 6'h15, 0, 1'b0, d, e);
        check("load_data", {26'd0, d}, 32'h15);
        check("load_err", {31'd0, e}, 32'd0);
        check("load_count", {24'd0, op_count}, 32'd1);
        run_cmd(1'b0, 4'hA, 6'h0F, 0, 1'b0, d, e);
        check("op_data", {26'd0, d}, 32'h1A);
        check("op_count2", {24'd0, op_count}, 32'd2);
        run_cmd(1'b0, 4'h3, 6'h01, 0, 1'b0, d, e);
        check("illegal_err", {31'd0, e}, 32'd1);
        check("illegal_data", {26'd0, d}, 32'h1A);
        check("illegal_count", {24'd0, op_count}, 32'd2);

        // Load with an illegal opcode alongside: load wins
        run_cmd(1'b1, 4'h2, 6'h2C, 0, 1'b0, d, e);
        check("load_sel_ignored", {26'd0, d}, 32'h2C);
        // Boundary opcodes 8 and 15, then 7 (illegal)
        run_cmd(1'b0, 4'h8, 6'h3F, 0, 1'b0, d, e);
        check("sel8_data", {26'd0, d}, 32'h13);
        run_cmd(1'b0, 4'hF, 6'h13, 0, 1'b0, d, e);
        check("sel15_data", {26'd0, d}, 32'h00);
        run_cmd(1'b0, 4'h7, 6'h11, 0, 1'b0, d, e);
        check("sel7_err", {31'd0, e}, 32'd1);

        // Backpressure for 5 cycles
        run_cmd(1'b0, 4'hC, 6'h2A, 5, 1'b0, d, e);
        check("bp_data", {26'd0, d}, 32'h2A);
        check("bp_count", {24'd0, op_count}, 32'd6);

        // Reset in the middle of RESP
        run_cmd(1'b0, 4'h9, 6'h05, 3, 1'b1, d, e);
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("after_rst_no_result", {31'd0, res_valid}, 32'd0);
            check("after_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        end

        // Counter wrap: 255 legal ops then a load of zero makes 256
        for (int i = 0; i < 255; i++) begin
            run_cmd(1'b0, 4'h8 + 4'(i % 8), 6'(i * 7 + 3), 0, 1'b0, d, e);
        end
        check("count_255", {24'd0, op_count}, 32'd255);
        run_cmd(1'b1, 4'h0, 6'h00, 0, 1'b0, d, e);
        check("wrap_count", {24'd0, op_count}, 32'd0);
        check("wrap_data", {26'd0, d}, 32'd0);
`ifdef ULA_SEQ_STATUS_EN
        check("wrap_zero", {31'd0, zero}, 32'd1);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
